// File: rtl/ex_mem_stage_hs_if.sv
// Bundle of the upstream operation handshake and the data-memory request bus
// seen by the execute+memory stage.
interface ex_mem_stage_hs_if #(
    parameter int ADDR_W = 12
) ();
    // Upstream: an operation transfers on a rising edge where in_valid && in_ready;
    // the producer must hold all operation fields stable until then.
    // Memory: mem_req stays high with stable mem_we/addr/wdata/wstrb until a rising
    // edge where mem_ready is high (or the stage aborts on timeout).
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       src_a;
    logic [31:0]       write_data;
    logic [31:0]       imm_ext;
    logic              alu_src;
    logic [2:0]        alu_control;
    logic [2:0]        funct3;
    logic              mem_read;
    logic              mem_write;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              out_valid;
    logic [31:0]       alu_result;
    logic              zero;
    logic [31:0]       read_data;
    logic              misaligned;
    logic              bus_error;

    modport master (
        output in_valid, src_a, write_data, imm_ext, alu_src, alu_control, funct3,
               mem_read, mem_write, mem_rdata, mem_ready,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               out_valid, alu_result, zero, read_data, misaligned, bus_error
    );

    modport slave (
        input  in_valid, src_a, write_data, imm_ext, alu_src, alu_control, funct3,
               mem_read, mem_write, mem_rdata, mem_ready,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               out_valid, alu_result, zero, read_data, misaligned, bus_error
    );
endinterface

// File: rtl/ex_mem_stage_hs.sv
// Registered execute+memory stage: one-cycle ALU, and a load/store engine that
// talks to data memory over req/ready with alignment checks and a wait timeout.
module ex_mem_stage_hs #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    ex_mem_stage_hs_if.slave bus,
    output logic dbg_state_o
);
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     alu_q, alu_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [2:0]      f3_q, f3_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            ov_q, ov_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        is_mem;
    logic        align_ok;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_lane;
    logic [31:0] ld_fmt;

    assign op_b   = bus.alu_src ? bus.imm_ext : bus.write_data;
    assign is_mem = bus.mem_read | bus.mem_write;

    always_comb begin
        alu_res = 32'd0;
        case (bus.alu_control)
            3'b000: alu_res = bus.src_a + op_b;
            3'b001: alu_res = bus.src_a - op_b;
            3'b010: alu_res = bus.src_a & op_b;
            3'b011: alu_res = bus.src_a | op_b;
            3'b100: alu_res = bus.src_a ^ op_b;
            3'b101: alu_res = {31'd0, $signed(bus.src_a) < $signed(op_b)};
            3'b110: alu_res = bus.src_a << op_b[4:0];
            3'b111: alu_res = bus.src_a >> op_b[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    // Alignment and store lane placement use the freshly computed address.
    always_comb begin
        align_ok = 1'b0;
        st_wdata = bus.write_data;
        st_wstrb = 4'b1111;
        case (bus.funct3[1:0])
            2'b00: begin
                align_ok = 1'b1;
                st_wdata = {4{bus.write_data[7:0]}};
                st_wstrb = 4'b0001 << alu_res[1:0];
            end
            2'b01: begin
                align_ok = ~alu_res[0];
                st_wdata = {2{bus.write_data[15:0]}};
                st_wstrb = 4'b0011 << alu_res[1:0];
            end
            2'b10: align_ok = (alu_res[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    // Load formatting uses the captured address and size of the pending access.
    assign ld_lane = bus.mem_rdata >> {alu_q[1:0], 3'b000};

    always_comb begin
        ld_fmt = bus.mem_rdata;
        case (f3_q[1:0])
            2'b00: ld_fmt = f3_q[2] ? {24'd0, ld_lane[7:0]}
                                    : {{24{ld_lane[7]}}, ld_lane[7:0]};
            2'b01: ld_fmt = f3_q[2] ? {16'd0, ld_lane[15:0]}
                                    : {{16{ld_lane[15]}}, ld_lane[15:0]};
            default: ld_fmt = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        rdata_d = 32'd0;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        f3_d    = f3_q;
        req_d   = req_q;
        we_d    = we_q;
        ov_d    = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    alu_d = alu_res;
                    if (!is_mem) begin
                        ov_d = 1'b1;
                    end else if (!align_ok) begin
                        ov_d  = 1'b1;
                        mis_d = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        req_d   = 1'b1;
                        we_d    = bus.mem_write;
                        wdata_d = bus.mem_write ? st_wdata : 32'd0;
                        wstrb_d = bus.mem_write ? st_wstrb : 4'd0;
                        f3_d    = bus.funct3;
                        cnt_d   = '0;
                    end
                end
            end
            S_ACCESS: begin
                // A ready arriving on the expiry cycle still completes normally.
                if (bus.mem_ready) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    rdata_d = we_q ? 32'd0 : ld_fmt;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alu_q   <= 32'd0;
            rdata_q <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            f3_q    <= 3'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ov_q    <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q    <= f3_d;
            req_q   <= req_d;
            we_q    <= we_d;
            ov_q    <= ov_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.mem_req    = req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = {alu_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wstrb  = wstrb_q;
    assign bus.out_valid  = ov_q;
    assign bus.alu_result = alu_q;
    assign bus.zero       = (alu_q == 32'd0);
    assign bus.read_data  = rdata_q;
    assign bus.misaligned = mis_q;
    assign bus.bus_error  = berr_q;
    assign dbg_state_o    = (state_q == S_ACCESS);
endmodule

// File: tb/tb_ex_mem_stage_hs.sv
// Directed and randomized checks of ex_mem_stage_hs against an arithmetic
// reference model of the ALU, alignment rules, lane placement and load formatting.
module tb_ex_mem_stage_hs;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    logic dbg_state;
    int   checks = 0;
    int   errors = 0;

    ex_mem_stage_hs_if #(.ADDR_W(12)) bus ();

    ex_mem_stage_hs #(.ADDR_W(12), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [2:0] ctl, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (ctl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] rdata, input int off,
                                               input logic [2:0] f3);
        logic [31:0] v;
        case (f3 % 4)
            0: begin
                v = (rdata >> (8 * off)) & 32'hFF;
                if (!f3[2] && v >= 128) v = v - 256;
            end
            1: begin
                v = (rdata >> (8 * off)) & 32'hFFFF;
                if (!f3[2] && v >= 32768) v = v - 65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, ":idle_ov"}, bus.out_valid, 0);
        chk({tag, ":idle_rd"}, bus.read_data, 0);
        chk({tag, ":idle_flags"}, {bus.misaligned, bus.bus_error, bus.mem_req}, 0);
        chk({tag, ":idle_rdy"}, bus.in_ready, 1);
    endtask

    // Called at a negedge with the stage idle; returns at the negedge where the
    // result is visible. delay = cycles of withheld ready (>= TO means timeout).
    task automatic run_op(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] imm, input logic asrc,
                          input logic [2:0] f3, input logic mr, input logic mw,
                          input int delay, input logic [31:0] rdata);
        logic [31:0] b, res, exp_rd, exp_wd;
        logic [3:0]  exp_strb;
        logic        is_mem, ok, done;
        int          off, size;
        b      = asrc ? imm : wd;
        res    = alu_model(ctl, a, b);
        is_mem = mr | mw;
        off    = res % 4;
        size   = f3 % 4;
        ok     = (size == 0) || (size == 1 && off % 2 == 0) || (size == 2 && off == 0);
        exp_strb = (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'hF;
        exp_wd   = (size == 0) ? (wd & 32'hFF) * 32'h01010101 :
                   (size == 1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

        chk({tag, ":in_ready"}, bus.in_ready, 1);
        bus.alu_control = ctl;
        bus.src_a       = a;
        bus.write_data  = wd;
        bus.imm_ext     = imm;
        bus.alu_src     = asrc;
        bus.funct3      = f3;
        bus.mem_read    = mr;
        bus.mem_write   = mw;
        bus.in_valid    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;

        if (!is_mem || !ok) begin
            chk({tag, ":ov"}, bus.out_valid, 1);
            chk({tag, ":alu"}, bus.alu_result, res);
            chk({tag, ":zero"}, bus.zero, (res == 0));
            chk({tag, ":mis"}, bus.misaligned, is_mem);
            chk({tag, ":berr"}, bus.bus_error, 0);
            chk({tag, ":rd"}, bus.read_data, 0);
            chk({tag, ":req"}, bus.mem_req, 0);
            chk({tag, ":rdy"}, bus.in_ready, 1);
            return;
        end

        done = 1'b0;
        for (int c = 0; c < TO; c++) begin
            chk({tag, ":acc_req"}, bus.mem_req, 1);
            chk({tag, ":acc_rdy"}, bus.in_ready, 0);
            chk({tag, ":acc_ov"}, bus.out_valid, 0);
            chk({tag, ":acc_dbg"}, dbg_state, 1);
            chk({tag, ":acc_we"}, bus.mem_we, mw);
            chk({tag, ":acc_addr"}, bus.mem_addr, res & 32'hFFC);
            chk({tag, ":acc_strb"}, bus.mem_wstrb, mw ? exp_strb : 4'd0);
            if (mw) chk({tag, ":acc_wdata"}, bus.mem_wdata, exp_wd);
            if (c == delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rdata;
                @(negedge clk);
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                done = 1'b1;
                break;
            end
            bus.mem_rdata = $urandom;
            @(negedge clk);
        end

        exp_rd = (done && !mw) ? load_model(rdata, off, f3) : 32'd0;
        chk({tag, ":ov"}, bus.out_valid, 1);
        chk({tag, ":berr"}, bus.bus_error, !done);
        chk({tag, ":mis"}, bus.misaligned, 0);
        chk({tag, ":rd"}, bus.read_data, exp_rd);
        chk({tag, ":alu"}, bus.alu_result, res);
        chk({tag, ":req"}, bus.mem_req, 0);
        chk({tag, ":rdy"}, bus.in_ready, 1);
        chk({tag, ":dbg"}, dbg_state, 0);
    endtask

    initial begin
        int kind;
        logic [2:0] f3;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.src_a       = 32'd0;
        bus.write_data  = 32'd0;
        bus.imm_ext     = 32'd0;
        bus.alu_src     = 1'b0;
        bus.alu_control = 3'd0;
        bus.funct3      = 3'd0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_rdata   = 32'd0;
        bus.mem_ready   = 1'b0;

        @(negedge clk);
        chk("rst:in_ready", bus.in_ready, 1);
        chk("rst:req_we", {bus.mem_req, bus.mem_we}, 0);
        chk("rst:addr", bus.mem_addr, 0);
        chk("rst:wdata", bus.mem_wdata, 0);
        chk("rst:wstrb", bus.mem_wstrb, 0);
        chk("rst:ov", bus.out_valid, 0);
        chk("rst:alu", bus.alu_result, 0);
        chk("rst:zero", bus.zero, 1);
        chk("rst:rd", bus.read_data, 0);
        chk("rst:flags", {bus.misaligned, bus.bus_error}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add", 3'd0, 32'd5, 32'd0, 32'd7, 1'b1, 3'd2, 1'b0, 1'b0, 0, 0);
        run_op("sub", 3'd1, 32'd9, 32'd9, 32'd0, 1'b0, 3'd2, 1'b0, 1'b0, 0, 0);
        run_op("xor", 3'd4, 32'hF0, 32'h0F, 32'd0, 1'b0, 3'd2, 1'b0, 1'b0, 0, 0);
        idle_check("after_alu");
        run_op("lb", 3'd0, 32'h100, 32'd0, 32'd3, 1'b1, 3'b000, 1'b1, 1'b0, 3, 32'h80123456);
        idle_check("after_lb");
        run_op("lbu", 3'd0, 32'h100, 32'd0, 32'd3, 1'b1, 3'b100, 1'b1, 1'b0, 3, 32'h80123456);
        run_op("sh", 3'd0, 32'h100, 32'hABCD, 32'd2, 1'b1, 3'b001, 1'b0, 1'b1, 1, 0);
        run_op("lw_mis", 3'd0, 32'h100, 32'd0, 32'd2, 1'b1, 3'b010, 1'b1, 1'b0, 0, 0);
        run_op("lh_mis", 3'd0, 32'h101, 32'd0, 32'd0, 1'b1, 3'b001, 1'b1, 1'b0, 0, 0);
        run_op("illegal", 3'd0, 32'h100, 32'd0, 32'd0, 1'b1, 3'b011, 1'b1, 1'b0, 0, 0);
        run_op("lw_to", 3'd0, 32'h40, 32'd0, 32'd0, 1'b1, 3'b010, 1'b1, 1'b0, TO, 32'h1234);
        idle_check("after_to");
        run_op("lw_edge", 3'd0, 32'h40, 32'd0, 32'd0, 1'b1, 3'b010, 1'b1, 1'b0, TO - 1,
               32'hCAFEF00D);
        run_op("lh_hi", 3'd0, 32'h3FFE, 32'd0, 32'd0, 1'b1, 3'b001, 1'b1, 1'b0, 0, 32'h9ABC0000);

        // Reset in the middle of a store access must drop the request at once.
        bus.alu_control = 3'd0;
        bus.src_a       = 32'h200;
        bus.imm_ext     = 32'd0;
        bus.alu_src     = 1'b1;
        bus.write_data  = 32'h55;
        bus.funct3      = 3'b010;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b1;
        bus.in_valid    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid:req_before", bus.mem_req, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid:req", bus.mem_req, 0);
        chk("mid:we", bus.mem_we, 0);
        chk("mid:in_ready", bus.in_ready, 1);
        chk("mid:addr", bus.mem_addr, 0);
        chk("mid:wstrb", bus.mem_wstrb, 0);
        chk("mid:alu_zero", {bus.alu_result[0], bus.zero}, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        idle_check("after_rst");
        run_op("recover", 3'd3, 32'hF000, 32'h000F, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            f3   = 3'($urandom_range(0, 7));
            if (kind == 0) begin
                run_op("rnd_alu", 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       1'($urandom_range(0, 1)), f3, 1'b0, 1'b0, 0, 0);
            end else begin
                run_op("rnd_mem", 3'd0, $urandom, $urandom, 32'($urandom_range(0, 15)), 1'b1, f3,
                       (kind != 2), (kind >= 2), $urandom_range(0, TO + 1), $urandom);
            end
            if ($urandom_range(0, 3) == 0) idle_check("rnd_idle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
